// File: rtl/mac_accum.sv
// mac_accum: framed signed multiply-accumulate around an external 8x8 multiplier,
// with saturating accumulation and valid/ready input and output streams.
module mac_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       x,
  input  logic signed [7:0]       y,
  input  logic [LEN_W-1:0]        len,
  output logic signed [7:0]       mul_x,
  output logic signed [7:0]       mul_y,
  input  logic signed [15:0]      mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_sat
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HOLD} state_t;
  state_t state_q, state_d;
  logic in_ready_q, a_valid_q, a_last_q, fin_q, sat_q, out_valid_q, out_sat_q;
  logic signed [7:0] mul_x_q, mul_y_q;
  logic [LEN_W-1:0] cnt_q, len_q, last_idx;
  logic signed [ACC_W-1:0] acc_q, acc_d, out_acc_q;
  logic signed [ACC_W:0] sum;
  logic accept, last, ovf;
  assign accept   = in_valid && in_ready_q;
  assign last_idx = ((state_q == IDLE) ? len : len_q) - LEN_W'(1);
  assign last     = cnt_q == last_idx;
  assign sum      = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(mul_p);
  assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_d    = !ovf ? sum[ACC_W-1:0] :
                    sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  // FLUSH waits for the final product to land in the accumulator (fin_q) before HOLD
  always_comb begin
    state_d = (state_q == IDLE || state_q == RUN) ? (accept ? (last ? FLUSH : RUN) : state_q) :
              (state_q == FLUSH) ? (fin_q ? HOLD : FLUSH) :
              (out_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      a_valid_q   <= 1'b0;
      a_last_q    <= 1'b0;
      fin_q       <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE) || (state_d == RUN);
      a_valid_q  <= accept;
      a_last_q   <= accept && last;
      fin_q      <= a_valid_q && a_last_q;
      if (accept) begin
        mul_x_q <= x;
        mul_y_q <= y;
        cnt_q   <= last ? '0 : cnt_q + LEN_W'(1);
        if (state_q == IDLE) len_q <= len;
      end
      if (a_valid_q) begin
        acc_q <= acc_d;
        sat_q <= sat_q | ovf;
      end else if (fin_q) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end
      if (fin_q) begin
        out_acc_q   <= acc_q;
        out_sat_q   <= sat_q;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
  assign in_ready  = in_ready_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: drives a 24-bit and a 17-bit accumulator instance in lockstep and
// checks frame results, latency, backpressure and reset against a saturating-sum model.
module tb_mac_accum;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [7:0] x = '0, y = '0;
  logic [7:0] len = '0;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_sat_a, out_sat_b;
  logic signed [7:0] mx_a, my_a, mx_b, my_b;
  logic signed [15:0] mp_a, mp_b;
  logic signed [23:0] acc_a;
  logic signed [16:0] acc_b;
  int n_cmp = 0, n_bad = 0, cnt_a = 0, cnt_b = 0;
  int qx[$], qy[$];

  assign mp_a = mx_a * my_a;
  assign mp_b = mx_b * my_b;

  always #5 clk = ~clk;

  mac_accum #(.ACC_W(24), .LEN_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .x(x), .y(y), .len(len), .mul_x(mx_a), .mul_y(my_a), .mul_p(mp_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(acc_a), .out_sat(out_sat_a));

  mac_accum #(.ACC_W(17), .LEN_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .x(x), .y(y), .len(len), .mul_x(mx_b), .mul_y(my_b), .mul_p(mp_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(acc_b), .out_sat(out_sat_b));

  always @(posedge clk) begin
    if (in_valid && in_ready_a) cnt_a <= cnt_a + 1;
    if (in_valid && in_ready_b) cnt_b <= cnt_b + 1;
  end

  typedef struct {
    logic [7:0] l;
    int np;
    logic [4:0][7:0] xs;
    logic [4:0][7:0] ys;
    int gap;
    int hold;
    longint ea;
    logic sa;
    longint eb;
    logic sb;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain saturating running sum of the products in the queue
  task automatic model(input int w, input int n, output longint r, output logic s);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    r = 0;
    s = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = r + qx[i] * qy[i];
      if (r > hi) begin r = hi; s = 1'b1; end
      if (r < lo) begin r = lo; s = 1'b1; end
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] l, input int gap, input int hold,
                           input longint ea, input logic sa, input longint eb, input logic sb);
    int n, w, stalls, unstable, ca0, cb0;
    n = (l == 0) ? 256 : int'(l);
    w = 0;
    while (in_ready_a !== 1'b1 && w < 20) begin tick; w++; end
    chk({tag, " start_ready"}, longint'(in_ready_a), 1);
    ca0 = cnt_a;
    cb0 = cnt_b;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      len = (i == 0) ? l : 8'($urandom);
      x = 8'(qx[i]);
      y = 8'(qy[i]);
      in_valid = 1'b1;
      stalls += int'(in_ready_a !== 1'b1) + int'(in_ready_b !== 1'b1);
      tick;
      in_valid = 1'b0;
      if (i < n - 1 && gap > 0)
        repeat ($urandom_range(gap, 1)) begin x = 8'($urandom); y = 8'($urandom); tick; end
    end
    chk({tag, " stalls"}, stalls, 0);
    chk({tag, " ready_after_last"}, longint'({in_ready_a, in_ready_b}), 0);
    tick;
    chk({tag, " valid_at_e1"}, longint'({out_valid_a, out_valid_b}), 0);
    tick;
    chk({tag, " valid_at_e2"}, longint'({out_valid_a, out_valid_b}), 3);
    chk({tag, " acc24"}, longint'(acc_a), ea);
    chk({tag, " sat24"}, longint'(out_sat_a), longint'(sa));
    chk({tag, " acc17"}, longint'(acc_b), eb);
    chk({tag, " sat17"}, longint'(out_sat_b), longint'(sb));
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      x = 8'($urandom);
      y = 8'($urandom);
      tick;
      unstable += int'(out_valid_a !== 1'b1 || out_valid_b !== 1'b1 || longint'(acc_a) != ea ||
                       longint'(acc_b) != eb || out_sat_a !== sa || out_sat_b !== sb ||
                       in_ready_a !== 1'b0 || in_ready_b !== 1'b0);
    end
    chk({tag, " hold_stable"}, unstable, 0);
    chk({tag, " mul_x_kept"}, longint'(mx_a), longint'(qx[n-1]));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, " after_xfer"}, longint'({out_valid_a, out_valid_b, in_ready_a, in_ready_b}), 3);
    chk({tag, " beats_a"}, cnt_a - ca0, n);
    chk({tag, " beats_b"}, cnt_b - cb0, n);
  endtask

  vec_t tbl[5];

  initial begin
    longint ea, eb;
    logic sa, sb;
    int bad, nn;
    tbl[0] = '{l: 1, np: 1, xs: {8'd0, 8'd0, 8'd0, 8'd0, 8'd3}, ys: {8'd0, 8'd0, 8'd0, 8'd0, -8'sd5},
               gap: 0, hold: 0, ea: -15, sa: 0, eb: -15, sb: 0};
    tbl[1] = '{l: 4, np: 4, xs: {8'd0, 8'd1, -8'sd128, -8'sd128, 8'd127},
               ys: {8'd0, -8'sd1, 8'd127, -8'sd128, 8'd127},
               gap: 0, hold: 5, ea: 16256, sa: 0, eb: 16256, sb: 0};
    tbl[2] = tbl[1];
    tbl[2].gap = 3;
    tbl[2].hold = 2;
    tbl[3] = '{l: 5, np: 5, xs: {5{-8'sd128}}, ys: {5{-8'sd128}},
               gap: 0, hold: 1, ea: 81920, sa: 0, eb: 65535, sb: 1};
    tbl[4] = '{l: 1, np: 1, xs: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, ys: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1},
               gap: 0, hold: 0, ea: 1, sa: 0, eb: 1, sb: 0};

    #12;
    chk("reset_state", longint'({in_ready_a, out_valid_a, out_sat_a, in_ready_b, out_valid_b}), 0);
    chk("reset_acc", longint'(acc_a) + longint'(acc_b) + longint'(mx_a) + longint'(my_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("ready_before_edge", longint'({in_ready_a, in_ready_b}), 0);
    tick;
    chk("ready_after_release", longint'({in_ready_a, in_ready_b}), 3);

    // Abort a frame mid-way with an asynchronous reset between edges
    len = 8'd4;
    x = 8'sd50;
    y = 8'sd50;
    in_valid = 1'b1;
    tick;
    len = 8'd9;
    tick;
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", longint'({in_ready_a, in_ready_b}), 0);
    chk("async_rst_mul", longint'({mx_a, my_a, mx_b, my_b}), 0);
    chk("async_rst_out", longint'({out_valid_a, out_sat_a, out_valid_b, out_sat_b}), 0);
    chk("async_rst_acc", longint'(acc_a) + longint'(acc_b), 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick;
    chk("ready_after_rerelease", longint'({in_ready_a, in_ready_b}), 3);
    bad = 0;
    repeat (8) begin tick; bad += int'(out_valid_a !== 1'b0 || out_valid_b !== 1'b0); end
    chk("no_aborted_result", bad, 0);

    for (int t = 0; t < 5; t++) begin
      qx.delete();
      qy.delete();
      for (int i = 0; i < tbl[t].np; i++) begin
        qx.push_back(int'($signed(tbl[t].xs[i])));
        qy.push_back(int'($signed(tbl[t].ys[i])));
      end
      run_frame($sformatf("vec%0d", t), tbl[t].l, tbl[t].gap, tbl[t].hold,
                tbl[t].ea, tbl[t].sa, tbl[t].eb, tbl[t].sb);
    end

    qx.delete();
    qy.delete();
    repeat (256) begin qx.push_back(-128); qy.push_back(-128); end
    run_frame("long", 8'd0, 0, 0, 64'h400000, 1'b0, 65535, 1'b1);

    for (int r = 0; r < 10; r++) begin
      nn = $urandom_range(12, 1);
      qx.delete();
      qy.delete();
      for (int i = 0; i < nn; i++) begin
        qx.push_back(($urandom_range(1, 0) == 1) ? int'($signed(8'($urandom))) : (($urandom_range(1, 0) == 1) ? -128 : 127));
        qy.push_back(($urandom_range(1, 0) == 1) ? int'($signed(8'($urandom))) : (($urandom_range(1, 0) == 1) ? -128 : 127));
      end
      model(24, nn, ea, sa);
      model(17, nn, eb, sb);
      run_frame($sformatf("rnd%0d", r), 8'(nn), $urandom_range(2, 0), $urandom_range(3, 0), ea, sa, eb, sb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
